// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-aware arbiter sharing the async FIFO write port among NUM_REQ producers.
// Grant is held per burst; released on last byte, burst limit, or requester idle timeout.
//
// state   | meaning
// S_IDLE  | no grant; pick next requester round-robin after last_q
// S_GRANT | requester last_q owns the FIFO write port
module fifo_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_in,
    input  logic [8*NUM_REQ-1:0]   data_in,
    input  logic [NUM_REQ-1:0]     last_in,
    output logic [NUM_REQ-1:0]     ack_out,
    input  logic                   fifo_full,
    output logic                   fifo_wr,
    output logic [7:0]             fifo_d,
    output logic [NUM_REQ-1:0]     grant_out,
    output logic                   busy_out
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic [7:0]         beat_q, beat_d;
    logic [7:0]         idle_q, idle_d;
    logic [7:0]         lane [NUM_REQ];
    logic               granted;
    logic               accept;
    logic               release_now;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            lane[i] = data_in[i*8 +: 8];
        end
    end

    // Scan starts one past the previous winner so every requester gets a turn.
    always_comb begin
        int cand;
        win_idx = last_q;
        win_vld = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_q) + k) % NUM_REQ;
            if (!win_vld && req_in[IDX_W'(cand)]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

    assign granted     = (state_q == S_GRANT);
    assign accept      = granted && req_in[last_q] && !fifo_full;
    assign release_now = (accept && (last_in[last_q] || (beat_q == 8'(MAX_BURST - 1))))
                       || (granted && !req_in[last_q] && (idle_q == 8'(IDLE_TIMEOUT - 1)));

    always_comb begin
        ack_out         = '0;
        ack_out[last_q] = accept;
        fifo_wr         = accept;
        fifo_d          = (|grant_out) ? lane[last_q] : 8'h00;
        busy_out        = granted;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_out;
        last_d  = last_q;
        beat_d  = beat_q;
        idle_d  = idle_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d          = S_GRANT;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    last_d           = win_idx;
                    beat_d           = 8'd0;
                    idle_d           = 8'd0;
                end
            end
            S_GRANT: begin
                // A full FIFO holds both counters: stalls are not idleness.
                if (release_now) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    beat_d  = 8'd0;
                    idle_d  = 8'd0;
                end else if (accept) begin
                    beat_d = beat_q + 8'd1;
                    idle_d = 8'd0;
                end else if (!req_in[last_q]) begin
                    idle_d = idle_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            grant_out <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            beat_q    <= 8'd0;
            idle_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            grant_out <= grant_d;
            last_q    <= last_d;
            beat_q    <= beat_d;
            idle_q    <= idle_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producers drain per-requester byte lists,
// a monitor checks every FIFO write against the expected byte order.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_in = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  last_in = '0;
    logic        fifo_full = 1'b0;
    logic [3:0]  ack_out;
    logic        fifo_wr;
    logic [7:0]  fifo_d;
    logic [3:0]  grant_out;
    logic        busy_out;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ      (4),
        .MAX_BURST    (16),
        .IDLE_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .ack_out   (ack_out),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_d    (fifo_d),
        .grant_out (grant_out),
        .busy_out  (busy_out)
    );

    logic [8:0]  mem [4][128];
    int          wp [4];
    int          rp [4];
    logic [10:0] sb [$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic prod(input int id, input logic [7:0] d, input logic l);
        mem[id][wp[id]] = {l, d};
        wp[id]++;
    endtask

    task automatic expect_byte(input int id, input logic [7:0] d);
        sb.push_back({3'(id), d});
    endtask

    task automatic send(input int id, input logic [7:0] d, input logic l);
        prod(id, d, l);
        expect_byte(id, d);
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    // Producers: present queue heads just after the falling edge, pop on acknowledged bytes.
    initial begin
        logic [3:0] ack_s;
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (rp[i] < wp[i]) begin
                    req_in[i]         = 1'b1;
                    data_in[i*8 +: 8] = mem[i][rp[i]][7:0];
                    last_in[i]        = mem[i][rp[i]][8];
                end else begin
                    req_in[i]         = 1'b0;
                    data_in[i*8 +: 8] = 8'h00;
                    last_in[i]        = 1'b0;
                end
            end
            #3;
            ack_s = ack_out;
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                if (ack_s[i]) rp[i]++;
            end
        end
    end

    // Monitor: every FIFO write must match the next expected byte and requester.
    initial begin
        logic [10:0] e;
        logic [3:0]  exp_oh;
        forever begin
            @(negedge clk);
            #4;
            if (fifo_wr === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL fifo_write: unexpected byte %02h ack %b", fifo_d, ack_out);
                end else begin
                    e      = sb.pop_front();
                    exp_oh = 4'b0001 << e[10:8];
                    if (fifo_full || fifo_d !== e[7:0] || ack_out !== exp_oh || grant_out !== exp_oh) begin
                        n_fail++;
                        $display("FAIL fifo_write: got d=%02h ack=%b grant=%b full=%b expected d=%02h ack=%b grant=%b full=0",
                                 fifo_d, ack_out, grant_out, fifo_full, e[7:0], exp_oh, exp_oh);
                    end
                end
            end
        end
    end

    initial begin
        int         wr_cnt;
        logic [3:0] e;

        // Reset with every requester pending, then 2-byte round-robin bursts.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(i, 8'hA0 + 8'(i * 2), 1'b0);
            send(i, 8'hA1 + 8'(i * 2), 1'b1);
        end
        send(0, 8'hC0, 1'b0);
        send(0, 8'hC1, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #3;
        chk("reset_grant_busy", 0, 32'({busy_out, grant_out}), 32'h0);
        chk("reset_wr_ack_d", 0, 32'({fifo_wr, ack_out, fifo_d}), 32'h0);

        wr_cnt = 0;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            #3;
            case (c)
                0, 1, 12, 13: e = 4'b0001;
                3, 4:         e = 4'b0010;
                6, 7:         e = 4'b0100;
                9, 10:        e = 4'b1000;
                default:      e = 4'b0000;
            endcase
            chk("rr_grant", c, 32'({busy_out, grant_out}), 32'({|e, e}));
            if (c <= 10 && fifo_wr) wr_cnt++;
        end
        chk("rr_wr_count", 10, 32'(wr_cnt), 32'd8);

        // Burst limit: 40 bytes split 16/16/8, then idle timeout.
        @(negedge clk);
        for (int k = 0; k < 40; k++) send(2, 8'(k), 1'b0);
        for (int c = 0; c <= 51; c++) begin
            @(negedge clk);
            #3;
            e = (c == 16 || c == 33 || c >= 50) ? 4'b0000 : 4'b0100;
            chk("burst_grant", c, 32'({busy_out, grant_out}), 32'({|e, e}));
        end

        // Full stall after byte 3 for 5 cycles; beat count resumes at 3.
        @(negedge clk);
        for (int k = 0; k < 20; k++) send(1, 8'h80 + 8'(k), 1'b0);
        for (int c = 0; c <= 35; c++) begin
            @(negedge clk);
            fifo_full = (c >= 3 && c <= 7);
            #3;
            e = (c == 21 || c >= 34) ? 4'b0000 : 4'b0010;
            chk("stall_grant", c, 32'({busy_out, grant_out}), 32'({|e, e}));
            if (c >= 3 && c <= 7) chk("stall_wr_ack", c, 32'({fifo_wr, ack_out}), 32'h0);
        end

        // Idle timeout with requester 0 waiting.
        @(negedge clk);
        send(1, 8'h51, 1'b0);
        for (int c = 0; c <= 19; c++) begin
            @(negedge clk);
            if (c == 1) send(0, 8'h50, 1'b0);
            #3;
            e = (c <= 8) ? 4'b0010 : ((c == 9 || c == 19) ? 4'b0000 : 4'b0001);
            chk("timeout_grant", c, 32'({busy_out, grant_out}), 32'({|e, e}));
        end

        // Byte re-presented on idle cycle 7 restarts the timeout.
        @(negedge clk);
        send(1, 8'h52, 1'b0);
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            if (c == 7) send(1, 8'h53, 1'b0);
            #3;
            e = (c <= 15) ? 4'b0010 : 4'b0000;
            chk("rearm_grant", c, 32'({busy_out, grant_out}), 32'({|e, e}));
        end

        // Reset on the 5th byte of a burst; priority restarts at requester 0.
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            prod(1, 8'h60 + 8'(k), (k == 9));
            if (k < 5) expect_byte(1, 8'h60 + 8'(k));
        end
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            if (c == 4) rst = 1'b0;
            if (c == 6) begin
                rst = 1'b1;
                send(0, 8'h70, 1'b1);
                for (int k = 5; k < 10; k++) expect_byte(1, 8'h60 + 8'(k));
                send(2, 8'h72, 1'b1);
            end
            #3;
            if (c <= 4 || (c >= 9 && c <= 13)) e = 4'b0010;
            else if (c == 7)                   e = 4'b0001;
            else if (c == 15)                  e = 4'b0100;
            else                               e = 4'b0000;
            chk("rstmid_grant", c, 32'({busy_out, grant_out}), 32'({|e, e}));
            if (c == 5) chk("rstmid_wr_ack_d", c, 32'({fifo_wr, ack_out, fifo_d}), 32'h0);
        end

        for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
        chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, burst-aware arbiter that shares the single 8-bit write port of the async FIFO among NUM_REQ producers in the write-clock domain.
- Grants one requester at a time and holds the grant for a burst.
- Forwards that requester's bytes to the FIFO's wr/d_in, gated by the FIFO full flag.
- Releases on end-of-burst, on burst-length limit, or on requester idle timeout.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, max accepted bytes per grant (1..255)
IDLE_TIMEOUT, 8, consecutive cycles with granted req low before forced release (1..255)

Ports:
clk  input  1  write-side clock (same clock as FIFO wr_clk_in)
rst  input  1  synchronous active-low reset
req_in  input  NUM_REQ  per-requester byte-valid
data_in  input  8*NUM_REQ  requester i byte on bits [8i+7:8i]
last_in  input  NUM_REQ  requester i marks current byte as end of burst
ack_out  output  NUM_REQ  byte accepted this cycle (one-hot or zero)
fifo_full  input  1  FIFO full flag
fifo_wr  output  1  FIFO write strobe
fifo_d  output  8  FIFO write data
grant_out  output  NUM_REQ  registered one-hot grant
busy_out  output  1  high in GRANT state

Behaviour:
- All state updates on posedge clk. rst=0 at a clock edge resets the block:
  - state=IDLE, grant_out=0, beat_cnt=0, idle_cnt=0, last_winner=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-burst abandons the burst; no partial-burst tracking survives.
- Outputs after reset:
  - busy_out=0, fifo_wr=0, ack_out=0.
  - fifo_d is 0 while no grant (mux output forced to 0 when grant_out=0).
- States: IDLE and GRANT.
- IDLE:
  - If any req_in bit is set, the winner is the first set bit scanning last_winner+1, last_winner+2, … modulo NUM_REQ.
  - Next cycle: grant_out=onehot(winner), last_winner=winner, state=GRANT, beat_cnt=0, idle_cnt=0.
  - If no requests, stay in IDLE.
  - No bytes are accepted in IDLE.
- GRANT, with g = granted index:
  - accept = req_in[g] & ~fifo_full. This is combinational.
  - fifo_wr = accept. fifo_d = data_in[g]. ack_out[g] = accept. All other ack bits are 0.
  - On accept: beat_cnt++ and idle_cnt=0.
  - Release (state to IDLE, grant_out to 0 next cycle) when any of these holds:
    - accept & last_in[g];
    - accept & beat_cnt==MAX_BURST-1;
    - idle_cnt==IDLE_TIMEOUT-1 and req_in[g]=0.
  - req_in[g]=0: idle_cnt++.
  - req_in[g]=1 & fifo_full=1: stall. No accept; beat_cnt and idle_cnt are held. Full is never counted as requester idleness, and a full FIFO never releases the grant.
  - Requests from non-granted requesters are ignored until the next IDLE cycle.
- Latency:
  - Request in IDLE cycle N gives grant at N+1. The first byte can be accepted in cycle N+1.
  - Exactly one bubble cycle (IDLE) between consecutive bursts.
- Throughput: one byte per cycle while granted, req high, and not full.
- Counter widths: beat_cnt and idle_cnt are 8 bits. They never exceed their limits, because release occurs at the limit.
- last_in is sampled only on accept. last_in without req_in has no effect.
- Requester protocol: hold data_in/last_in stable while req_in high and ack low.
- fifo_wr is never asserted when fifo_full=1. Exactly one requester drives the FIFO at any time.

Test Plan:
- Reset/idle: rst=0 for 2 cycles with all req_in=1. Then check grant_out=0, fifo_wr=0, busy_out=0, fifo_d=0. Release rst, req_in=4'b1111: grant_out=4'b0001 one cycle later.
- Round-robin: all four requesters each send 2-byte bursts (last on 2nd byte) continuously. Grant sequence is 0,1,2,3,0. Bytes reach FIFO in order. One IDLE cycle between bursts. 8 fifo_wr pulses in 11 cycles after first grant.
- Burst limit: requester 2 streams 40 bytes with last_in=0 and requester 3 idle. Grants are 16, 16, 8 bytes, each preceded by a bubble. Then requester 2 is regranted because no other request is pending.
- Full stall: during a burst, after byte 3, assert fifo_full for 5 cycles. fifo_wr=0 and ack_out=0 for those 5 cycles, and grant is held. After full drops, bytes 4.. resume, and beat_cnt continues from 3 (release at 16th accepted byte).
- Idle timeout: requester 1 is granted, sends 1 byte, then drops req_in. The grant is released after exactly 8 idle cycles. Requester 0, pending, is granted on the following cycle+1. A byte re-presented by 1 on idle cycle 7 is accepted and resets idle_cnt.
- Reset mid-burst: assert rst=0 on the 5th byte of a burst. The next cycle shows grant_out=0 and fifo_wr=0. After release, arbitration restarts with requester 0 priority.
